joypad_ctrl: RTL
================

# joypad_ctrl

Debounce and scan controller for the eight Game Boy buttons. One shared prescaler and a round-robin scheduler service the buttons one per tick, each with its own stability counter. The block presents the debounced state to the P1 (0xFF00) register logic as active-low nibbles selected by P14/P15, and raises the joypad interrupt request on a new press.

## Interface
- TICK_DIV, 4167: clock cycles per service tick; legal range ≥ 2. The default is 125 µs at 33.3333 MHz, giving a 1 ms full scan.
- STABLE_TICKS, 10: consecutive differing services needed to accept a change; legal range 1..15.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_raw  in  8  raw buttons, 1 = pressed, asynchronous. Bit order {start, select, b, a, down, up, left, right}.
- p1_sel  in  2  P1 select bits, active-low. Bit 0 is P14 (direction group, btn bits 3:0); bit 1 is P15 (action group, btn bits 7:4).
- p1_out  out  4  P1 bits 3:0, active-low, registered.
- btn_state  out  8  debounced button state, 1 = pressed.
- irq  out  1  one-cycle joypad interrupt request pulse.

## Operation
- **Input sync.** Each btn_raw bit passes through a two-flop synchronizer giving sync[7:0].
- **Prescaler.** A counter runs 0..TICK_DIV-1 and wraps. It asserts tick for one cycle when count == TICK_DIV-1.
- **Scheduler.** A 3-bit scan index idx wraps 7→0, so each button is serviced once per 8 ticks.
- **State machine.** States are IDLE, SAMPLE and UPDATE.
  - IDLE → SAMPLE on tick.
  - SAMPLE: latch s = sync[idx] and the current cnt[idx]; → UPDATE.
  - UPDATE: apply the rule below, then idx ← idx+1 and → IDLE.
- **UPDATE rule** (cnt[i] is a 4-bit per-button counter):
  - If s == btn_state[idx]: cnt[idx] ← 0.
  - Else if cnt[idx]+1 == STABLE_TICKS: btn_state[idx] ← s and cnt[idx] ← 0.
  - Else: cnt[idx] ← cnt[idx]+1.
  - A bounce back to the stable value during counting clears the count. Acceptance therefore needs STABLE_TICKS consecutive services that all disagree.
- **P1 output.** Registered every cycle:
  - p1_out[i] = ~((~p1_sel[0] & btn_state[i]) | (~p1_sel[1] & btn_state[i+4])).
  - Both selects low: the two groups are ORed.
  - Both selects high: 4'hF.
- **irq.** Pulses for the cycle after an UPDATE that changes btn_state[idx] from 0 to 1, provided that button's group select is low in that UPDATE cycle. Releases never raise irq.
- **Reset (asynchronous, any time including mid-service).**
  - btn_state = 0, all cnt = 0, idx = 0, prescaler = 0, state = IDLE, synchronizers = 0.
  - Outputs: p1_out = 4'hF, irq = 0.
  - After release, scanning restarts from idx 0; no press is remembered.

## Timing
- Tick period is TICK_DIV cycles. Service period per button is 8·TICK_DIV cycles.
- SAMPLE occurs 1 cycle after tick; UPDATE 2 cycles after tick.
- btn_state changes at the end of UPDATE. irq is high in the following cycle; p1_out reflects the change 1 cycle after btn_state.
- **Press-acceptance latency** from a btn_raw edge held stable:
  - Minimum: 2 + (STABLE_TICKS-1)·8·TICK_DIV + 2 cycles.
  - Maximum: the minimum plus 8·TICK_DIV.
- A change in p1_sel reaches p1_out in 1 cycle.
- With TICK_DIV = 2, the FSM (3 cycles per service) misses alternate ticks. TICK_DIV ≥ 3 is therefore required for the stated latency; TICK_DIV = 2 is legal but slower.

## Configuration
- **JOYPAD_IRQ_EN defined:** irq is generated as described.
- **JOYPAD_IRQ_EN undefined:** irq is tied to 0, and the press-detect logic and select qualification are not built. Debounce and p1_out behaviour are identical in both builds.

## Test plan
All scenarios use TICK_DIV = 4 and STABLE_TICKS = 3, so each button is serviced every 32 cycles.
- **Reset values:** assert reset for 5 cycles, release → p1_out = 4'hF, btn_state = 0, irq = 0. Re-assert reset mid-count → btn_state stays 0 and scanning restarts at idx 0.
- **Clean press:** p1_sel = 2'b01, hold btn_raw[4] (A) = 1 → btn_state[4] rises 68..100 cycles after the edge. irq pulses exactly once, and p1_out = 4'b1110 one cycle after btn_state.
- **Bounce rejection:** toggle btn_raw[0] every 40 cycles for 400 cycles → btn_state[0] stays 0 and irq never fires.
- **Masked interrupt:** p1_sel = 2'b11, press btn_raw[3] (down) → btn_state[3] = 1, irq = 0, p1_out = 4'hF.
- **Group mixing:** btn_state = 8'b0001_0010, p1_sel = 2'b00 → p1_out = 4'b1100. Change p1_sel to 2'b10 → p1_out = 4'b1101 next cycle.
- **Release and wrap:** release a pressed button → btn_state clears after 3 disagreeing services with no irq. Confirm idx wraps 7→0 by pressing btn_raw[7] and btn_raw[0] in the same cycle → both accepted within 100 cycles.

Source files
------------

// File: rtl/joypad_ctrl.sv
// joypad_ctrl: Game Boy joypad with a synchronizer, a debouncer serviced round-robin, and the P1 nibble mux.
// Optional build macro JOYPAD_IRQ_EN adds the press interrupt; without it irq is tied low.
module joypad_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module joypad_ctrl #(
  parameter int TICK_DIV     = 4167,
  parameter int STABLE_TICKS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] btn_raw,
  input  logic [1:0] p1_sel,
  output logic [3:0] p1_out,
  output logic [7:0] btn_state,
  output logic       irq
);
  localparam int         PW = $clog2(TICK_DIV);
  localparam logic [3:0] ST = 4'(STABLE_TICKS);

  typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE} state_t;

  state_t            state;
  logic [7:0]        sync;
  logic [PW-1:0]     pre;
  logic              tick;
  logic [2:0]        idx;
  logic [7:0][3:0]   cnt;
  logic              s_lat;
  logic [3:0]        c_lat;
  logic [3:0]        c_nxt;
  logic              accept;

  for (genvar i = 0; i < 8; i++) begin : g_sync
    joypad_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d     (btn_raw[i]),
      .q     (sync[i])
    );
  end

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  assign c_nxt  = c_lat + 4'd1;
  assign accept = (s_lat != btn_state[idx]) && (c_nxt == ST);

  // One button per tick; ticks arriving while SAMPLE/UPDATE are busy are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      s_lat     <= 1'b0;
      c_lat     <= '0;
      cnt       <= '0;
      btn_state <= '0;
    end else begin
      case (state)
        IDLE: if (tick) state <= SAMPLE;
        SAMPLE: begin
          s_lat <= sync[idx];
          c_lat <= cnt[idx];
          state <= UPDATE;
        end
        UPDATE: begin
          if (s_lat == btn_state[idx]) begin
            cnt[idx] <= '0;
          end else if (accept) begin
            btn_state[idx] <= s_lat;
            cnt[idx]       <= '0;
          end else begin
            cnt[idx] <= c_nxt;
          end
          idx   <= idx + 3'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) p1_out <= 4'hF;
    else        p1_out <= ~(({4{~p1_sel[0]}} & btn_state[3:0]) |
                            ({4{~p1_sel[1]}} & btn_state[7:4]));
  end

`ifdef JOYPAD_IRQ_EN
  logic grp_sel;

  // Buttons 7:4 belong to the P15 group, 3:0 to P14.
  assign grp_sel = idx[2] ? ~p1_sel[1] : ~p1_sel[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (state == UPDATE) && accept && s_lat && grp_sel;
  end
`else
  assign irq = 1'b0;
`endif
endmodule
